regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back arbiter for the 32x64 architectural register file, which has a single write port. It shares that port among N write-back requesters (ALU, load unit, multiplier, ...) using round-robin arbitration with a valid/ready handshake. It registers the winning write and decodes it into the register file's one-hot 32-bit enable and 64-bit data inputs. Writes to X31 (XZR) complete the handshake but are discarded.

Parameters:
NREQ, 3, number of write-back requesters (2..8)
GW, $clog2(NREQ) (min 1), width of grant_id

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester write request valid
req_ready  output  NREQ  per-requester accept; at most one bit high
req_addr  input  NREQ*5  packed destination register index, requester i at [5i+4:5i]
req_data  input  NREQ*64  packed write data, requester i at [64i+63:64i]
hold  input  1  write-back stall; no grant issued while high
wr_enable  output  32  registered one-hot write enable to the register file
wr_data  output  64  registered write data to the register file
wr_valid  output  1  registered; a grant was issued last cycle, including a dropped XZR write
grant_id  output  GW  registered index of the last granted requester

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state is reset only on a clk edge with reset=1.
- Reset values:
  - wr_enable=0, wr_data=0, wr_valid=0, grant_id=0.
  - Round-robin pointer rr_ptr=0, so requester 0 has highest priority.
  - While reset=1, req_ready=0 (combinational mask).
- Arbitration (combinational, every cycle with reset=0 and hold=0):
  - Winner g is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g]=1; all other ready bits are 0.
  - If no requester is valid, req_ready=0.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer occurs when req_valid[i] & req_ready[i]. On the next edge:
  - wr_valid<=1, grant_id<=g, wr_data<=req_data[g].
  - wr_enable<=onehot(req_addr[g]) if the address is not 31; else wr_enable<=0.
  - rr_ptr<=(g+1) mod NREQ.
- Idle edge (no transfer, reset=0):
  - wr_enable<=0, wr_valid<=0.
  - wr_data and grant_id hold their values; rr_ptr is unchanged.
- Hold:
  - hold=1 forces req_ready=0; the edge is treated as idle.
  - hold is sampled the same cycle as arbitration, with no lookahead.
- Latency: a request accepted in cycle t drives wr_enable/wr_data throughout cycle t+1. The register file captures it at the end of cycle t+1.
- Throughput: one write per cycle. Back-to-back grants with no bubble.
- Requester obligation: once req_valid[i]=1, hold req_valid, req_addr and req_data stable until the transfer.
- XZR (addr 31):
  - The handshake completes, wr_valid=1, grant_id updates and rr_ptr advances.
  - wr_enable stays 0 (bit 31 is never driven).
- Fairness: a continuously valid requester is granted within NREQ grants.
- Wrap-around: rr_ptr after granting NREQ-1 is 0.
- Simultaneous events:
  - reset has priority over hold and over any transfer. No write is issued on the edge where reset=1.
  - A request presented during reset is not accepted and must be re-presented (kept valid) afterwards.
- Reset mid-operation: a write registered before reset is cleared at the reset edge (wr_enable=0). Pending unaccepted requests are unaffected except that rr_ptr returns to 0.
- wr_enable is always zero or one-hot. req_ready is always zero or one-hot. Both are checked by assertions in the bench.

Test Plan:
- Reset: reset=1 for 2 cycles with req_valid=3'b111 → req_ready=0, wr_enable=0, wr_valid=0. First cycle after reset → req_ready=3'b001.
- Single write: req_valid=3'b010, req_addr[1]=5, req_data[1]=64'h1f → req_ready=3'b010 the same cycle. Next cycle: wr_enable=32'h0000_0020, wr_data=64'h1f, grant_id=1, wr_valid=1. The following cycle: wr_enable=0.
- Round-robin: all three valid continuously with addrs 1/2/3 (re-presenting after each accept) → grant_id sequence 0,1,2,0,1,2. wr_enable sequence 32'h2, 32'h4, 32'h8 repeating, with no idle cycles.
- XZR drop: req_valid=3'b001, req_addr[0]=31, data 64'hdead → ready[0]=1. Next cycle: wr_valid=1, wr_enable=0, grant_id=0. Then with 3'b011 valid → requester 1 is granted first.
- Hold: hold=1 for 3 cycles with req_valid=3'b101 and rr_ptr=1 → req_ready=0, wr_enable=0. On release → requester 2 granted, then requester 0.
- Mid-stream reset: after requester 1 is granted, assert reset for 1 cycle → wr_enable=0 at the reset edge. Afterwards, with 3'b011 valid → requester 0 is granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the single register-file write port among NREQ requesters.
// Registers the winning write and decodes it to a one-hot enable; writes to X31 are acknowledged but dropped.
module regfile_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*5-1:0]  req_addr,
    input  logic [NREQ*64-1:0] req_data,
    input  logic               hold,
    output logic [31:0]        wr_enable,
    output logic [63:0]        wr_data,
    output logic               wr_valid,
    output logic [GW-1:0]      grant_id
);

    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]   wr_enable_q;
    logic [63:0]   wr_data_q;
    logic          wr_valid_q;
    logic [GW-1:0] grant_id_q;

    logic [GW-1:0] grant;
    logic          found;
    logic          transfer;
    logic [4:0]    sel_addr;
    logic [63:0]   sel_data;
    logic [31:0]   dec_enable;

    // Scan from rr_ptr upward, wrapping modulo NREQ; first valid requester wins.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = (int'(rr_ptr_q) + k) % int'(NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = GW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!reset && !hold && found) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);
    assign sel_addr = req_addr[int'(grant)*5 +: 5];
    assign sel_data = req_data[int'(grant)*64 +: 64];

    always_comb begin
        dec_enable = '0;
        if (sel_addr != 5'd31) begin
            dec_enable[sel_addr] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (transfer) begin
            rr_ptr_d = (int'(grant) == int'(NREQ) - 1) ? '0 : grant + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            wr_enable_q <= '0;
            wr_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            grant_id_q  <= '0;
        end else if (transfer) begin
            rr_ptr_q    <= rr_ptr_d;
            wr_enable_q <= dec_enable;
            wr_data_q   <= sel_data;
            wr_valid_q  <= 1'b1;
            grant_id_q  <= grant;
        end else begin
            wr_enable_q <= '0;
            wr_valid_q  <= 1'b0;
        end
    end

    assign wr_enable = wr_enable_q;
    assign wr_data   = wr_data_q;
    assign wr_valid  = wr_valid_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter (NREQ=3), plus a bounded fairness sequence.
module tb_regfile_wb_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned GW   = 2;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*5-1:0]  req_addr;
    logic [NREQ*64-1:0] req_data;
    logic               hold;
    logic [31:0]        wr_enable;
    logic [63:0]        wr_data;
    logic               wr_valid;
    logic [GW-1:0]      grant_id;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .hold      (hold),
        .wr_enable (wr_enable),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert ($onehot0(wr_enable)) else $error("FAIL onehot wr_enable got %h", wr_enable);
        assert ($onehot0(req_ready)) else $error("FAIL onehot req_ready got %b", req_ready);
    end

    typedef struct {
        logic         rst;
        logic         hld;
        logic [2:0]   valid;
        logic [14:0]  addr;
        logic [191:0] data;
        logic [2:0]   exp_ready;
        logic         exp_wv;
        logic [31:0]  exp_we;
        logic [63:0]  exp_wd;
        logic [1:0]   exp_gid;
    } vec_t;

    localparam logic [14:0]  ADEF = {5'd3, 5'd2, 5'd1};
    localparam logic [191:0] DDEF = {64'h102, 64'h101, 64'h100};
    localparam logic [14:0]  AONE = {5'd3, 5'd5, 5'd1};
    localparam logic [191:0] DONE = {64'h102, 64'h1f, 64'h100};
    localparam logic [14:0]  AXZR = {5'd3, 5'd2, 5'd31};
    localparam logic [191:0] DXZR = {64'h102, 64'h101, 64'hdead};

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic h, logic [2:0] v, logic [14:0] a, logic [191:0] d,
                                logic [2:0] er, logic ewv, logic [31:0] ewe, logic [63:0] ewd,
                                logic [1:0] eg);
        vec_t x;
        x.rst = r; x.hld = h; x.valid = v; x.addr = a; x.data = d;
        x.exp_ready = er; x.exp_wv = ewv; x.exp_we = ewe; x.exp_wd = ewd; x.exp_gid = eg;
        return x;
    endfunction

    task automatic check(string name, int idx, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    initial begin
        int cyc;
        logic saw_gap;
        reset = 1'b1; hold = 1'b0; req_valid = '0; req_addr = ADEF; req_data = DDEF;

        // Reset held two cycles with all requesters valid.
        vecs.push_back(mk(1, 0, 3'b111, ADEF, DDEF, 3'b000, 0, 32'h0, 64'h0, 2'd0));
        vecs.push_back(mk(1, 0, 3'b111, ADEF, DDEF, 3'b000, 0, 32'h0, 64'h0, 2'd0));
        // Round-robin, back-to-back.
        vecs.push_back(mk(0, 0, 3'b111, ADEF, DDEF, 3'b001, 1, 32'h2, 64'h100, 2'd0));
        vecs.push_back(mk(0, 0, 3'b111, ADEF, DDEF, 3'b010, 1, 32'h4, 64'h101, 2'd1));
        vecs.push_back(mk(0, 0, 3'b111, ADEF, DDEF, 3'b100, 1, 32'h8, 64'h102, 2'd2));
        vecs.push_back(mk(0, 0, 3'b111, ADEF, DDEF, 3'b001, 1, 32'h2, 64'h100, 2'd0));
        vecs.push_back(mk(0, 0, 3'b111, ADEF, DDEF, 3'b010, 1, 32'h4, 64'h101, 2'd1));
        vecs.push_back(mk(0, 0, 3'b111, ADEF, DDEF, 3'b100, 1, 32'h8, 64'h102, 2'd2));
        // Idle: data and grant_id hold.
        vecs.push_back(mk(0, 0, 3'b000, ADEF, DDEF, 3'b000, 0, 32'h0, 64'h102, 2'd2));
        // Single write from requester 1 to x5.
        vecs.push_back(mk(0, 0, 3'b010, AONE, DONE, 3'b010, 1, 32'h20, 64'h1f, 2'd1));
        vecs.push_back(mk(0, 0, 3'b000, AONE, DONE, 3'b000, 0, 32'h0, 64'h1f, 2'd1));
        // XZR write: handshake completes, enable stays low, pointer advances to 1.
        vecs.push_back(mk(0, 0, 3'b001, AXZR, DXZR, 3'b001, 1, 32'h0, 64'hdead, 2'd0));
        vecs.push_back(mk(0, 0, 3'b011, ADEF, DDEF, 3'b010, 1, 32'h4, 64'h101, 2'd1));
        // Bring rr_ptr to 1, then hold three cycles.
        vecs.push_back(mk(0, 0, 3'b001, ADEF, DDEF, 3'b001, 1, 32'h2, 64'h100, 2'd0));
        vecs.push_back(mk(0, 1, 3'b101, ADEF, DDEF, 3'b000, 0, 32'h0, 64'h100, 2'd0));
        vecs.push_back(mk(0, 1, 3'b101, ADEF, DDEF, 3'b000, 0, 32'h0, 64'h100, 2'd0));
        vecs.push_back(mk(0, 1, 3'b101, ADEF, DDEF, 3'b000, 0, 32'h0, 64'h100, 2'd0));
        vecs.push_back(mk(0, 0, 3'b101, ADEF, DDEF, 3'b100, 1, 32'h8, 64'h102, 2'd2));
        vecs.push_back(mk(0, 0, 3'b001, ADEF, DDEF, 3'b001, 1, 32'h2, 64'h100, 2'd0));
        // Mid-stream reset after granting requester 1; pointer returns to 0.
        vecs.push_back(mk(0, 0, 3'b010, ADEF, DDEF, 3'b010, 1, 32'h4, 64'h101, 2'd1));
        vecs.push_back(mk(1, 0, 3'b011, ADEF, DDEF, 3'b000, 0, 32'h0, 64'h0, 2'd0));
        vecs.push_back(mk(0, 0, 3'b011, ADEF, DDEF, 3'b001, 1, 32'h2, 64'h100, 2'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; hold = vecs[i].hld; req_valid = vecs[i].valid;
            req_addr = vecs[i].addr; req_data = vecs[i].data;
            #1;
            check("req_ready", i, 64'(req_ready), 64'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check("wr_valid", i, 64'(wr_valid), 64'(vecs[i].exp_wv));
            check("wr_enable", i, 64'(wr_enable), 64'(vecs[i].exp_we));
            check("wr_data", i, wr_data, vecs[i].exp_wd);
            check("grant_id", i, 64'(grant_id), 64'(vecs[i].exp_gid));
        end

        // Fairness: rr_ptr is 1, all valid; requester 2 must win on the second grant.
        cyc = 0;
        saw_gap = 1'b0;
        req_valid = 3'b111;
        req_addr = ADEF; req_data = DDEF;
        while (cyc < 2 * int'(NREQ)) begin
            @(negedge clk);
            #1;
            cyc++;
            if (req_ready[2]) break;
            @(posedge clk);
            #1;
            if (!wr_valid) saw_gap = 1'b1;
        end
        check("fair_cycles", 0, 64'(cyc), 64'd2);
        check("fair_no_bubble", 0, 64'(saw_gap), 64'd0);
        @(posedge clk);
        #1;
        check("fair_grant_id", 0, 64'(grant_id), 64'd2);
        check("fair_wr_enable", 0, 64'(wr_enable), 64'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
